// File: rtl/dsi_pkg.sv
// Shared DSI definitions: data types, FSM states, CRC constants, header/ECC helpers.
package dsi_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [5:0] DT_DCS_SHORT_WR0 = 6'h05;
  localparam logic [5:0] DT_DCS_SHORT_WR1 = 6'h15;
  localparam logic [5:0] DT_DCS_LONG_WR   = 6'h39;

  localparam logic [15:0] CRC_SEED      = 16'hFFFF;
  localparam logic [15:0] CRC_POLY_REFL = 16'h8408;

  typedef enum logic [2:0] {
    IDLE,
    LP_SETUP,
    HEADER,
    PAYLOAD,
    TAIL,
    LP_HOLD
  } state_t;

  // DSI header Hamming code over {WC_hi, WC_lo, DI}; top two bits are always 0.
  function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
    logic [7:0] e;
    e[0] = ^(d & 24'hF12CB7);
    e[1] = ^(d & 24'hF2555B);
    e[2] = ^(d & 24'h749A6D);
    e[3] = ^(d & 24'hB8E38E);
    e[4] = ^(d & 24'hDF03F0);
    e[5] = ^(d & 24'hEFFC00);
    e[7:6] = 2'b00;
    return e;
  endfunction

  // Packet header word, DI in the low byte.
  function automatic logic [31:0] header_word(input logic [7:0] di, input logic [15:0] wc);
    return {dsi_ecc({wc, di}), wc[15:8], wc[7:0], di};
  endfunction

endpackage

// File: rtl/dsi_crc16.sv
// Reflected CRC-16-CCITT over up to four bytes per cycle, byte-enabled.
// Compiled only when DSI_PACKET_CRC_EN is defined.
`ifdef DSI_PACKET_CRC_EN
module dsi_crc16
  import dsi_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        upd,
  input  logic [31:0] data,
  input  logic [3:0]  be,
  output logic [15:0] crc,
  output logic [15:0] crc_next
);

  logic [15:0] c;

  // Next checksum after folding in the enabled bytes, byte 0 first, LSB first.
  always_comb begin
    c = crc;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        c = c ^ {8'h00, data[8*b +: 8]};
        for (int i = 0; i < 8; i++) begin
          c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
      end
    end
    crc_next = c;
  end

  // Running checksum register, reseeded at each packet start.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_SEED;
    end else if (clr) begin
      crc <= CRC_SEED;
    end else if (upd) begin
      crc <= crc_next;
    end
  end

endmodule
`endif

// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler: frames short/long packets into 32-bit words for the lanes controller.
// Optional payload checksum: define DSI_PACKET_CRC_EN, otherwise checksum bytes are zero.
module dsi_packet_assembler
  import dsi_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pkt_rqst,
  input  logic        pkt_long,
  input  logic        pkt_lp,
  input  logic [7:0]  pkt_data_id,
  input  logic [15:0] pkt_wc,
  output logic        pkt_busy,
  input  logic [31:0] pld_data,
  input  logic        pld_valid,
  output logic        pld_ready,
  output logic [31:0] iface_write_data,
  output logic [3:0]  iface_write_strb,
  output logic        iface_write_rqst,
  output logic        iface_last_word,
  output logic        iface_lpm_en,
  input  logic        iface_data_rqst,
  output logic        err_underflow
);

  state_t      state;
  logic        long_q;
  logic        lp_q;
  logic        tail_hi_q;
  logic [7:0]  di_q;
  logic [15:0] wc_q;
  logic [15:0] rem_q;
  logic        pop;
  logic [2:0]  nb;
  logic [3:0]  be;
  logic [31:0] mask;
  logic [31:0] pld_word;
  logic [31:0] pw;
  logic [3:0]  ps;
  logic        pl;
  logic [15:0] crc_q;
  logic [15:0] crc_n;

  // Payload pop decision and masking of bytes beyond the word count.
  always_comb begin
    nb = (rem_q >= 16'd4) ? 3'd4 : 3'(rem_q);
    case (nb)
      3'd0:    be = 4'b0000;
      3'd1:    be = 4'b0001;
      3'd2:    be = 4'b0011;
      3'd3:    be = 4'b0111;
      default: be = 4'b1111;
    endcase
    mask     = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    pld_word = (pld_valid ? pld_data : 32'h0) & mask;
    pop      = iface_data_rqst && (rem_q != 16'd0) && ((state == HEADER) || (state == PAYLOAD));
  end

  // The pop happens on the same edge that loads the word, so the source sees it combinationally.
  assign pld_ready = pop;

  // Next payload word; the last one absorbs as many checksum bytes as fit.
  always_comb begin
    pw = pld_word;
    ps = 4'b1111;
    pl = 1'b0;
    case (rem_q)
      16'd1: begin
        pw = {8'h00, crc_n, pld_word[7:0]};
        ps = 4'b0111;
        pl = 1'b1;
      end
      16'd2: begin
        pw = {crc_n, pld_word[15:0]};
        pl = 1'b1;
      end
      16'd3:   pw = {crc_n[7:0], pld_word[23:0]};
      default: ;
    endcase
  end

`ifdef DSI_PACKET_CRC_EN
  logic start;
  assign start = (state == IDLE) && pkt_rqst;

  dsi_crc16 u_crc (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .clr      (start),
    .upd      (pop),
    .data     (pld_word),
    .be       (be),
    .crc      (crc_q),
    .crc_next (crc_n)
  );
`else
  assign crc_q = 16'h0000;
  assign crc_n = 16'h0000;
`endif

  // Packet sequencing FSM with registered sink-side outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      long_q           <= 1'b0;
      lp_q             <= 1'b0;
      tail_hi_q        <= 1'b0;
      di_q             <= 8'h00;
      wc_q             <= 16'h0000;
      rem_q            <= 16'h0000;
      pkt_busy         <= 1'b0;
      err_underflow    <= 1'b0;
      iface_write_data <= 32'h0;
      iface_write_strb <= 4'h0;
      iface_write_rqst <= 1'b0;
      iface_last_word  <= 1'b0;
      iface_lpm_en     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pkt_rqst) begin
            long_q        <= pkt_long;
            lp_q          <= pkt_lp;
            di_q          <= pkt_data_id;
            wc_q          <= pkt_wc;
            rem_q         <= pkt_long ? pkt_wc : 16'h0000;
            tail_hi_q     <= 1'b0;
            err_underflow <= 1'b0;
            pkt_busy      <= 1'b1;
            if (pkt_lp) begin
              state        <= LP_SETUP;
              iface_lpm_en <= 1'b1;
            end else begin
              state            <= HEADER;
              iface_write_data <= header_word(pkt_data_id, pkt_wc);
              iface_write_strb <= 4'b1111;
              iface_write_rqst <= 1'b1;
              iface_last_word  <= ~pkt_long;
            end
          end
        end
        LP_SETUP: begin
          state            <= HEADER;
          iface_write_data <= header_word(di_q, wc_q);
          iface_write_strb <= 4'b1111;
          iface_write_rqst <= 1'b1;
          iface_last_word  <= ~long_q;
        end
        HEADER, PAYLOAD, TAIL: begin
          if (iface_data_rqst) begin
            if (iface_last_word) begin
              iface_write_data <= 32'h0;
              iface_write_strb <= 4'h0;
              iface_write_rqst <= 1'b0;
              iface_last_word  <= 1'b0;
              if (lp_q) begin
                state <= LP_HOLD;
              end else begin
                state    <= IDLE;
                pkt_busy <= 1'b0;
              end
            end else if (rem_q != 16'd0) begin
              state            <= PAYLOAD;
              iface_write_data <= pw;
              iface_write_strb <= ps;
              iface_last_word  <= pl;
              tail_hi_q        <= (rem_q == 16'd3);
              rem_q            <= (rem_q > 16'd4) ? (rem_q - 16'd4) : 16'h0000;
              if (!pld_valid) begin
                err_underflow <= 1'b1;
              end
            end else begin
              state           <= TAIL;
              iface_last_word <= 1'b1;
              if (tail_hi_q) begin
                iface_write_data <= {24'h0, crc_q[15:8]};
                iface_write_strb <= 4'b0001;
              end else begin
                iface_write_data <= {16'h0, crc_q};
                iface_write_strb <= 4'b0011;
              end
            end
          end
        end
        LP_HOLD: begin
          state        <= IDLE;
          iface_lpm_en <= 1'b0;
          pkt_busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
